// File: rtl/polyphase_fir_pkg.sv
// polyphase_fir_pkg: shared constants, types and default prototype taps for the polyphase FIR blocks
package polyphase_fir_pkg;
  localparam int L = 4;
  localparam int NTAPS = 63;
  localparam int NTAPS_PAD = 64;
  localparam int TAPS_PER_PHASE = NTAPS_PAD / L;
  localparam int COEF_FRAC = 15;
  typedef logic signed [15:0] coef_t;
  typedef coef_t [0:NTAPS-1] coef_arr_t;
  typedef enum logic {IDLE, ISSUE} state_t;
  // Triangular lowpass; every phase sums to exactly 32768, giving unity DC gain after upsampling by L
  function automatic coef_arr_t def_coefs();
    coef_arr_t h;
    for (int k = 0; k < NTAPS; k++) h[k] = coef_t'(128 * (32 - (k > 31 ? k - 31 : 31 - k)));
    return h;
  endfunction
  localparam coef_arr_t DEF_COEFS = def_coefs();
endpackage

// File: rtl/polyphase_fir_interpolator_63tap_phase_mac.sv
// polyphase_fir_phase_mac: 16-tap parallel multiply/adder tree with one register stage
module polyphase_fir_phase_mac
  import polyphase_fir_pkg::*;
#(
  parameter int DW = 16,
  parameter int ACC_W = 2 * DW + 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  coef_t [0:TAPS_PER_PHASE-1]             coefs,
  input  logic  [0:TAPS_PER_PHASE-1][DW-1:0]     taps,
  output logic signed [ACC_W-1:0]                acc,
  output logic                                   acc_valid
);
  logic signed [ACC_W-1:0] sum;
  always_comb begin
    sum = '0;
    for (int m = 0; m < TAPS_PER_PHASE; m++) sum = sum + ACC_W'($signed(coefs[m]) * $signed(taps[m]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= en;
      if (en) acc <= sum;
    end
  end
endmodule

// File: rtl/polyphase_fir_interpolator_63tap.sv
// polyphase_fir_interpolator_63tap: x4 upsampler with 63-tap image-reject FIR as four polyphase sub-filters
module polyphase_fir_interpolator_63tap
  import polyphase_fir_pkg::*;
#(
  parameter int        DATA_WIDTH = 16,
  parameter coef_arr_t COEFS      = DEF_COEFS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         dout_valid,
  output logic signed [DATA_WIDTH-1:0] dout
);
  localparam int ACC_W = 2 * DATA_WIDTH + 4;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);
  state_t state, state_nxt;
  logic [1:0] phase, phase_nxt;
  logic xfer, acc_valid;
  logic [0:TAPS_PER_PHASE-1][DATA_WIDTH-1:0] dly;
  coef_t [0:TAPS_PER_PHASE-1] csel;
  logic signed [ACC_W-1:0] acc, rnd;
  assign xfer = din_valid && din_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end
  always_comb begin
    state_nxt = (xfer || (state == ISSUE && phase != 2'(L - 1))) ? ISSUE : IDLE;
    phase_nxt = xfer ? '0 : (state == ISSUE ? phase + 2'd1 : phase);
  end
  always_comb din_ready = state == IDLE || phase == 2'(L - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dly <= '0;
    else if (xfer) dly <= {din, dly[0:TAPS_PER_PHASE-2]};
  end
  // Padded tap h[63] selects to zero
  always_comb begin
    csel = '0;
    for (int m = 0; m < TAPS_PER_PHASE; m++)
      csel[m] = (L * m + int'(phase) < NTAPS) ? COEFS[L * m + int'(phase)] : '0;
  end
  polyphase_fir_phase_mac #(.DW(DATA_WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ISSUE),
    .coefs     (csel),
    .taps      (dly),
    .acc       (acc),
    .acc_valid (acc_valid)
  );
  always_comb rnd = (acc + ACC_W'(2 ** (COEF_FRAC - 1))) >>> COEF_FRAC;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= acc_valid;
      if (acc_valid) dout <= rnd > MAX_V ? DATA_WIDTH'(MAX_V) : rnd < MIN_V ? DATA_WIDTH'(MIN_V) : DATA_WIDTH'(rnd);
    end
  end
endmodule

// File: tb/tb_polyphase_fir_interpolator_63tap.sv
// tb_polyphase_fir_interpolator_63tap: scoreboard bench over three coefficient sets sharing one stimulus stream
module tb_polyphase_fir_interpolator_63tap;
  import polyphase_fir_pkg::*;
  localparam coef_arr_t C_SAT = {63{16'h4000}};
  localparam coef_arr_t C_RND = {16'h0001, {62{16'h0000}}};
  typedef struct {
    logic [2:0][15:0] y;
    int               edge_n;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic signed [15:0] din = '0;
  logic rdy [3];
  logic dv [3];
  logic signed [15:0] dout [3];
  int cyc = 0, n_cmp = 0, n_bad = 0, last_xfer = -100;
  int hist [16];
  exp_t q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  polyphase_fir_interpolator_63tap #(.DATA_WIDTH(16), .COEFS(DEF_COEFS)) u_def (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[0]), .din(din), .dout_valid(dv[0]), .dout(dout[0]));
  polyphase_fir_interpolator_63tap #(.DATA_WIDTH(16), .COEFS(C_SAT)) u_sat (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[1]), .din(din), .dout_valid(dv[1]), .dout(dout[1]));
  polyphase_fir_interpolator_63tap #(.DATA_WIDTH(16), .COEFS(C_RND)) u_rnd (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[2]), .din(din), .dout_valid(dv[2]), .dout(dout[2]));

  // y[nL+p] = sat(round(sum_m h[p+4m] * x[n-m])), with h[63] = 0
  function automatic logic signed [15:0] ref_y(input coef_arr_t h, input int p);
    longint acc = 0;
    for (int m = 0; m < 16; m++)
      if (p + 4 * m < NTAPS) acc += longint'($signed(h[p + 4 * m])) * longint'(hist[m]);
    acc = (acc + 16384) >>> 15;
    return acc > 32767 ? 16'sh7fff : acc < -32768 ? 16'sh8000 : 16'(acc);
  endfunction

  task automatic chk(input string nm, input int i, input longint act, input longint exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s inst%0d edge %0d: got %0d expected %0d", nm, i, cyc, act, exp_v);
    end
  endtask

  // Reference model: a transfer decided before edge cyc+1 yields phase p at edge cyc+3+p
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int m = 0; m < 16; m++) hist[m] = 0;
      last_xfer <= -100;
    end else if (din_valid && rdy[0]) begin
      exp_t e;
      for (int m = 15; m > 0; m--) hist[m] = hist[m - 1];
      hist[0] = int'(din);
      for (int p = 0; p < 4; p++) begin
        e.edge_n = cyc + 3 + p;
        e.y[0] = ref_y(DEF_COEFS, p);
        e.y[1] = ref_y(C_SAT, p);
        e.y[2] = ref_y(C_RND, p);
        q.push_back(e);
      end
      last_xfer <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    bit due;
    bit exp_rdy;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        chk("rst_dout", i, longint'(dout[i]), 0);
        chk("rst_dout_valid", i, longint'(dv[i]), 0);
        chk("rst_din_ready", i, longint'(rdy[i]), 1);
      end
    end else begin
      due = q.size() > 0 && q[0].edge_n == cyc;
      exp_rdy = !((cyc - last_xfer) >= 0 && (cyc - last_xfer) <= 2);
      for (int i = 0; i < 3; i++) begin
        chk("dout_valid", i, longint'(dv[i]), longint'(due));
        chk("din_ready", i, longint'(rdy[i]), longint'(exp_rdy));
        if (due) chk("dout", i, longint'(dout[i]), longint'($signed(q[0].y[i])));
      end
      if (due) void'(q.pop_front());
    end
  end

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] x, input int gap);
    bit ok = 1'b0;
    din = x;
    din_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: din_ready got 0 for 50 cycles expected 1");
    end
    @(posedge clk);
    #1;
    if (gap > 0) idle(gap);
  endtask

  initial begin
    int sat_v [3] = '{32767, -32768, 1};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(16384, 0);
    repeat (15) send(0, 0);
    idle(8);
    send(1000, 10);
    for (int s = 0; s < 3; s++) begin
      repeat (17) send(16'(sat_v[s]), 0);
      idle(6);
    end
    send(16384, 3);
    send(16383, 3);
    send(-16384, 3);
    send(12345, 0);
    din_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    repeat (600) send(16'($urandom), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5)));
    din_valid = 1'b0;
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    chk("drain_pending", 0, longint'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
